// File: rtl/cve2_imem_resp_pkg.sv
// Shared types and constants for the instruction-memory responder.
// The LFSR constants are only used when CVE2_IMEM_RESP_STALL_EN is defined.
package cve2_imem_resp_pkg;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_stage_t;

  // Fibonacci taps 8,6,5,4 map to register bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int unsigned LATENCY_MIN     = 1;
  localparam int unsigned LATENCY_MAX     = 4;
  localparam int unsigned OUTSTANDING_MIN = 1;
  localparam int unsigned OUTSTANDING_MAX = 4;

endpackage

// File: rtl/cve2_imem_resp_lfsr.sv
// 8-bit Fibonacci LFSR that flags roughly one cycle in four as a grant stall.
// Only instantiated when CVE2_IMEM_RESP_STALL_EN is defined.
module cve2_imem_resp_lfsr
  import cve2_imem_resp_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  output logic stall_o
);

  logic [7:0] lfsr_reg;
  logic       feedback;

  assign feedback = ^(lfsr_reg & LFSR_TAPS);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], feedback};
    end
  end

  assign stall_o = (lfsr_reg[1:0] == 2'b00);

endmodule

// File: rtl/cve2_imem_responder.sv
// Fetch-bus target: grants word reads within an outstanding limit and returns
// in-order responses a fixed latency later. Optional grant stalls: CVE2_IMEM_RESP_STALL_EN.
module cve2_imem_responder
  import cve2_imem_resp_pkg::*;
#(
  parameter logic [31:0] MEM_BASE        = 32'h0000_0000,
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         instr_req_i,
  input  logic [31:0]                  instr_addr_i,
  output logic                         instr_gnt_o,
  output logic                         instr_rvalid_o,
  output logic [31:0]                  instr_rdata_o,
  output logic                         instr_err_o,
  output logic                         mem_req_o,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
  input  logic [31:0]                  mem_rdata_i,
  output logic                         busy_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  if (RESP_LATENCY < LATENCY_MIN || RESP_LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("RESP_LATENCY out of range");
  end
  if (MAX_OUTSTANDING < OUTSTANDING_MIN || MAX_OUTSTANDING > OUTSTANDING_MAX) begin : g_bad_outstanding
    $error("MAX_OUTSTANDING out of range");
  end
  if (MEM_WORDS < 16 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
    $error("MEM_WORDS must be a power of two and at least 16");
  end

  logic stall;

`ifdef CVE2_IMEM_RESP_STALL_EN
  cve2_imem_resp_lfsr u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .stall_o (stall)
  );
`else
  assign stall = 1'b0;
`endif

  logic [CW-1:0] cnt_reg;
  logic [31:0]   off;
  logic          in_range;
  logic          gnt;
  logic          rvalid;

  // Addresses below the base wrap to huge offsets and fall out of range.
  assign off      = instr_addr_i - MEM_BASE;
  assign in_range = (off >> 2) < 32'(MEM_WORDS);

  assign gnt         = ~rst_i & instr_req_i & (cnt_reg < CW'(MAX_OUTSTANDING)) & ~stall;
  assign instr_gnt_o = gnt;
  assign mem_req_o   = gnt & in_range;
  assign mem_addr_o  = mem_req_o ? off[2 +: AW] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else begin
      case ({gnt, rvalid})
        2'b10:   cnt_reg <= cnt_reg + CW'(1);
        2'b01:   cnt_reg <= cnt_reg - CW'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  assign busy_o = (cnt_reg != '0);

  resp_stage_t pipe_reg [RESP_LATENCY];
  resp_stage_t stage_in [RESP_LATENCY];

  // Stage 0 records the grant; stage 1 picks up SRAM data one cycle later.
  for (genvar gi = 0; gi < RESP_LATENCY; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign stage_in[gi] = {gnt, gnt & ~in_range, 32'd0};
    end else if (gi == 1) begin : g_data
      assign stage_in[gi] = {pipe_reg[0].valid, pipe_reg[0].err,
                             (pipe_reg[0].valid & ~pipe_reg[0].err) ? mem_rdata_i : 32'd0};
    end else begin : g_shift
      assign stage_in[gi] = pipe_reg[gi-1];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(RESP_LATENCY); i++) begin
      if (rst_i) begin
        pipe_reg[i] <= '0;
      end else begin
        pipe_reg[i] <= stage_in[i];
      end
    end
  end

  resp_stage_t out_stage;
  assign out_stage      = pipe_reg[RESP_LATENCY-1];
  assign rvalid         = out_stage.valid;
  assign instr_rvalid_o = rvalid;
  assign instr_err_o    = out_stage.valid & out_stage.err;

  if (RESP_LATENCY == 1) begin : g_rdata_direct
    assign instr_rdata_o = (out_stage.valid & ~out_stage.err) ? mem_rdata_i : 32'd0;
  end else begin : g_rdata_staged
    assign instr_rdata_o = out_stage.rdata;
  end

endmodule

// File: tb/tb_cve2_imem_responder.sv
// Directed bench: four responder configurations driven in sequence, each with
// a registered-read SRAM model; every check is an immediate assertion.
module tb_cve2_imem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index 0: L1/M2 base 0, 1: L2/M2, 2: L3/M1, 3: L3/M2 base 0x1000 16 words
  logic        req   [4];
  logic [31:0] addr  [4];
  logic        gnt   [4];
  logic        rv    [4];
  logic        err   [4];
  logic        mreq  [4];
  logic        busy  [4];
  logic [31:0] rd    [4];
  logic [31:0] mrd   [4];
  logic [9:0]  maddr [3];
  logic [3:0]  maddr_d;

  int n_assert = 0;
  int n_fail   = 0;

  cve2_imem_responder #(.MEM_BASE(32'h0), .MEM_WORDS(1024), .RESP_LATENCY(1), .MAX_OUTSTANDING(2)) u_a (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req[0]), .instr_addr_i(addr[0]), .instr_gnt_o(gnt[0]),
    .instr_rvalid_o(rv[0]), .instr_rdata_o(rd[0]), .instr_err_o(err[0]), .mem_req_o(mreq[0]),
    .mem_addr_o(maddr[0]), .mem_rdata_i(mrd[0]), .busy_o(busy[0]));

  cve2_imem_responder #(.MEM_BASE(32'h0), .MEM_WORDS(1024), .RESP_LATENCY(2), .MAX_OUTSTANDING(2)) u_b (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req[1]), .instr_addr_i(addr[1]), .instr_gnt_o(gnt[1]),
    .instr_rvalid_o(rv[1]), .instr_rdata_o(rd[1]), .instr_err_o(err[1]), .mem_req_o(mreq[1]),
    .mem_addr_o(maddr[1]), .mem_rdata_i(mrd[1]), .busy_o(busy[1]));

  cve2_imem_responder #(.MEM_BASE(32'h0), .MEM_WORDS(1024), .RESP_LATENCY(3), .MAX_OUTSTANDING(1)) u_c (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req[2]), .instr_addr_i(addr[2]), .instr_gnt_o(gnt[2]),
    .instr_rvalid_o(rv[2]), .instr_rdata_o(rd[2]), .instr_err_o(err[2]), .mem_req_o(mreq[2]),
    .mem_addr_o(maddr[2]), .mem_rdata_i(mrd[2]), .busy_o(busy[2]));

  cve2_imem_responder #(.MEM_BASE(32'h1000), .MEM_WORDS(16), .RESP_LATENCY(3), .MAX_OUTSTANDING(2)) u_d (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req[3]), .instr_addr_i(addr[3]), .instr_gnt_o(gnt[3]),
    .instr_rvalid_o(rv[3]), .instr_rdata_o(rd[3]), .instr_err_o(err[3]), .mem_req_o(mreq[3]),
    .mem_addr_o(maddr_d), .mem_rdata_i(mrd[3]), .busy_o(busy[3]));

  // SRAM contents: word 4 holds DEADBEEF, every other word w holds C0DE_0000 | w.
  function automatic logic [31:0] sram_word(input logic [9:0] w);
    return (w == 10'd4) ? 32'hDEAD_BEEF : {16'hC0DE, 6'd0, w};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mreq[i]) mrd[i] <= sram_word(maddr[i]);
    end
    if (mreq[3]) mrd[3] <= sram_word({6'd0, maddr_d});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit c = expected value in cycle c of each loop.
  localparam logic [7:0]  G_B  = 8'b0001_1011;
  localparam logic [7:0]  RV_B = 8'b0110_1100;
  localparam logic [11:0] G_C  = 12'b0001_0001_0001;
  localparam logic [11:0] RV_C = 12'b1000_1000_1000;
  localparam logic [11:0] BY_C = 12'b1110_1110_1110;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int j;
    logic [31:0] data_b [4];
    data_b[0] = 32'hC0DE_0000;
    data_b[1] = 32'hC0DE_0001;
    data_b[2] = 32'hC0DE_0002;
    data_b[3] = 32'hC0DE_0003;

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req[i]  = 1'b0;
      addr[i] = 32'h0;
    end

    // Reset: grant forced low even with a request present.
    step();
    req[0]  = 1'b1;
    addr[0] = 32'h10;
    step();
    #2;
    chk("rst_gnt",    32'(gnt[0]),   0);
    chk("rst_rvalid", 32'(rv[0]),    0);
    chk("rst_err",    32'(err[0]),   0);
    chk("rst_rdata",  rd[0],         0);
    chk("rst_memreq", 32'(mreq[0]),  0);
    chk("rst_memadr", 32'(maddr[0]), 0);
    chk("rst_busy",   32'(busy[0]),  0);

`ifndef CVE2_IMEM_RESP_STALL_EN
    // Single fetch at latency 1.
    step(); rst = 1'b0; #2;
    chk("a_c0_gnt",    32'(gnt[0]),   1);
    chk("a_c0_memreq", 32'(mreq[0]),  1);
    chk("a_c0_memadr", 32'(maddr[0]), 4);
    chk("a_c0_busy",   32'(busy[0]),  0);
    chk("a_c0_rvalid", 32'(rv[0]),    0);
    step(); req[0] = 1'b0; #2;
    chk("a_c1_rvalid", 32'(rv[0]),    1);
    chk("a_c1_rdata",  rd[0],         32'hDEAD_BEEF);
    chk("a_c1_err",    32'(err[0]),   0);
    chk("a_c1_busy",   32'(busy[0]),  1);
    step(); #2;
    chk("a_c2_busy",   32'(busy[0]),  0);
    chk("a_c2_rvalid", 32'(rv[0]),    0);
    chk("a_c2_rdata",  rd[0],         0);
    // Low address bits are ignored.
    step(); req[0] = 1'b1; addr[0] = 32'h17; #2;
    chk("a_c3_gnt",    32'(gnt[0]),   1);
    chk("a_c3_memadr", 32'(maddr[0]), 5);
    step(); req[0] = 1'b0; #2;
    chk("a_c4_rdata",  rd[0],         32'hC0DE_0005);

    // Back-to-back at latency 2 / limit 2: the counter is registered, so the
    // cycle the first response returns still sees a full pipe and skips a grant.
    k = 0;
    j = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      req[1]  = (k < 4);
      addr[1] = 32'(k * 4);
      #2;
      chk($sformatf("b_c%0d_gnt", c),    32'(gnt[1]), 32'(G_B[c]));
      chk($sformatf("b_c%0d_rvalid", c), 32'(rv[1]),  32'(RV_B[c]));
      if (RV_B[c]) begin
        chk($sformatf("b_c%0d_rdata", c), rd[1], data_b[j]);
        j++;
      end else begin
        chk($sformatf("b_c%0d_rdata0", c), rd[1], 0);
      end
      if (G_B[c]) k++;
    end

    // Limit 1 at latency 3 with request held high.
    for (int c = 0; c < 12; c++) begin
      step();
      req[2]  = (c < 10);
      addr[2] = 32'h20;
      #2;
      chk($sformatf("c_c%0d_gnt", c),    32'(gnt[2]),  32'(G_C[c]));
      chk($sformatf("c_c%0d_rvalid", c), 32'(rv[2]),   32'(RV_C[c]));
      chk($sformatf("c_c%0d_busy", c),   32'(busy[2]), 32'(BY_C[c]));
      if (RV_C[c]) chk($sformatf("c_c%0d_rdata", c), rd[2], 32'hC0DE_0008);
    end
    step(); #2;
    chk("c_end_busy", 32'(busy[2]), 0);

    // Out-of-range: one past the window, then one word below the base.
    step(); req[3] = 1'b1; addr[3] = 32'h1040; #2;
    chk("d_oor0_gnt",    32'(gnt[3]),  1);
    chk("d_oor0_memreq", 32'(mreq[3]), 0);
    step(); addr[3] = 32'h0FFC; #2;
    chk("d_oor1_gnt",    32'(gnt[3]),  1);
    chk("d_oor1_memreq", 32'(mreq[3]), 0);
    step(); req[3] = 1'b0; #2;
    chk("d_oor2_busy",   32'(busy[3]), 1);
    chk("d_oor2_rvalid", 32'(rv[3]),   0);
    for (int c = 3; c < 5; c++) begin
      step(); #2;
      chk($sformatf("d_oor%0d_rvalid", c), 32'(rv[3]),  1);
      chk($sformatf("d_oor%0d_err", c),    32'(err[3]), 1);
      chk($sformatf("d_oor%0d_rdata", c),  rd[3],       0);
    end
    step(); #2;
    chk("d_oor5_rvalid", 32'(rv[3]),   0);
    chk("d_oor5_busy",   32'(busy[3]), 0);

    // Reset one cycle after two grants drops both responses.
    step(); req[3] = 1'b1; addr[3] = 32'h1004; #2;
    chk("d_r0_memadr", 32'(maddr_d), 1);
    step(); addr[3] = 32'h1008; #2;
    chk("d_r1_gnt",    32'(gnt[3]),  1);
    step(); req[3] = 1'b0; rst = 1'b1; #2;
    chk("d_r2_gnt",    32'(gnt[3]),  0);
    for (int c = 3; c < 8; c++) begin
      step(); rst = 1'b0; #2;
      chk($sformatf("d_r%0d_rvalid", c), 32'(rv[3]),   0);
      chk($sformatf("d_r%0d_busy", c),   32'(busy[3]), 0);
    end
    step(); req[3] = 1'b1; addr[3] = 32'h103C; #2;
    chk("d_r8_gnt",    32'(gnt[3]),  1);
    chk("d_r8_memreq", 32'(mreq[3]), 1);
    chk("d_r8_memadr", 32'(maddr_d), 15);
    step(); req[3] = 1'b0; #2;
    step(); #2;
    chk("d_r10_rvalid", 32'(rv[3]), 0);
    step(); #2;
    chk("d_r11_rvalid", 32'(rv[3]),  1);
    chk("d_r11_err",    32'(err[3]), 0);
    chk("d_r11_rdata",  rd[3],       32'hC0DE_000F);
`else
    // Stall stress on the latency-1 instance: scoreboard of grant cycles.
    begin
      int grant_cycles [$];
      int grants;
      int first;
      grants = 0;
      step(); rst = 1'b0; req[0] = 1'b1; addr[0] = 32'h0; #2;
      for (int c = 0; c < 1003; c++) begin
        if (c > 0) begin
          step();
          req[0] = (c < 1000);
          #2;
        end
        if (rv[0]) begin
          if (grant_cycles.size() == 0) begin
            chk("stall_extra_resp", 32'(rv[0]), 0);
          end else begin
            first = grant_cycles.pop_front();
            chk("stall_latency", 32'(c - first), 1);
            chk("stall_rdata", rd[0], 32'hC0DE_0000);
          end
        end
        if (gnt[0]) begin
          grant_cycles.push_back(c);
          grants++;
        end
      end
      chk("stall_lost_resp", 32'(grant_cycles.size()), 0);
      chk("stall_ratio", 32'((grants >= 700) && (grants <= 800)), 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
